i2c_slave_sequencer: RTL

Transaction controller for the I2C slave datapath. Consumes the bit-timer's phase flags (byte received, ACK prepare/check/done) plus START/STOP detection and sequences a complete slave transaction: address match, R/W capture, ACK/NACK generation, RX FIFO push, TX FIFO pop/load and master-ACK checking. Sits between the bit timer, the shift register/SDA driver, and the APB-side FIFOs and config registers.

---
 rtl/i2c_slave_pkg.sv | 28 ++
 rtl/slave_flag_edge.sv | 40 ++++
 rtl/i2c_slave_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave transaction sequencer.
package i2c_slave_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned MODE_W = 2;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } seq_state_e;

    // SDA driver modes
    localparam logic [MODE_W-1:0] SDA_RELEASE = 2'b00;
    localparam logic [MODE_W-1:0] SDA_ACK     = 2'b01;
    localparam logic [MODE_W-1:0] SDA_TX      = 2'b10;

    // Byte shifted out when the master reads from an empty TX FIFO
    localparam logic [DATA_W-1:0] IDLE_FILL = 8'hFF;

endpackage

// File: rtl/slave_flag_edge.sv
// Registers the bit-timer ACK phase levels and produces single-cycle rising-edge strobes.
module slave_flag_edge (
    input  logic clk,
    input  logic n_rst,
    input  logic ack_prep,
    input  logic ack_check,
    input  logic ack_done,
    output logic prep_rise_c,
    output logic check_rise_c,
    output logic done_rise_c
);

    logic prep_q, check_q, done_q;
    logic prep_d, check_d, done_d;

    // Next flag history is simply the current level
    always_comb begin
        prep_d  = ack_prep;
        check_d = ack_check;
        done_d  = ack_done;
    end

    // Flag history registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prep_q  <= 1'b0;
            check_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            prep_q  <= prep_d;
            check_q <= check_d;
            done_q  <= done_d;
        end
    end

    assign prep_rise_c  = ack_prep  & ~prep_q;
    assign check_rise_c = ack_check & ~check_q;
    assign done_rise_c  = ack_done  & ~done_q;

endmodule

// File: rtl/i2c_slave_sequencer.sv
// I2C slave transaction sequencer: address match, ACK/NACK, RX push and TX load/pop.
module i2c_slave_sequencer
    import i2c_slave_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [6:0] slave_addr,
    input  logic       start,
    input  logic       stop,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       ack_check,
    input  logic       ack_done,
    input  logic [7:0] rx_data,
    input  logic       sda_in,
    input  logic       tx_fifo_empty,
    input  logic       rx_fifo_full,
    input  logic [7:0] tx_fifo_rdata,
    output logic [1:0] sda_mode,
    output logic       load_tx,
    output logic [7:0] tx_byte,
    output logic       tx_pop,
    output logic       rx_push,
    output logic [7:0] rx_wdata,
    output logic       rw_mode,
    output logic       busy,
    output logic       addr_match,
    output logic       overrun,
    output logic       underrun,
    output logic       master_nack
);

    logic prep_rise_c, check_rise_c, done_rise_c;

    seq_state_e          state_q, state_d;
    logic [MODE_W-1:0]   sda_mode_q, sda_mode_d;
    logic                rw_mode_q, rw_mode_d;
    logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
    logic [DATA_W-1:0]   rx_wdata_q, rx_wdata_d;
    logic                nack_q, nack_d;
    logic                busy_q, busy_d;
    logic                load_tx_q, load_tx_d;
    logic                tx_pop_q, tx_pop_d;
    logic                rx_push_q, rx_push_d;
    logic                addr_match_q, addr_match_d;
    logic                overrun_q, overrun_d;
    logic                underrun_q, underrun_d;
    logic                master_nack_q, master_nack_d;
    logic                tx_load_c;

    slave_flag_edge u_flag_edge (
        .clk          (clk),
        .n_rst        (n_rst),
        .ack_prep     (ack_prep),
        .ack_check    (ack_check),
        .ack_done     (ack_done),
        .prep_rise_c  (prep_rise_c),
        .check_rise_c (check_rise_c),
        .done_rise_c  (done_rise_c)
    );

    // Next-state and next-output decode for the whole transaction
    always_comb begin
        state_d       = state_q;
        sda_mode_d    = sda_mode_q;
        rw_mode_d     = rw_mode_q;
        tx_byte_d     = tx_byte_q;
        rx_wdata_d    = rx_wdata_q;
        nack_d        = nack_q;
        load_tx_d     = 1'b0;
        tx_pop_d      = 1'b0;
        rx_push_d     = 1'b0;
        addr_match_d  = 1'b0;
        overrun_d     = 1'b0;
        underrun_d    = 1'b0;
        master_nack_d = 1'b0;
        tx_load_c     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start && en) begin
                state_d    = ST_ADDR;
                sda_mode_d = SDA_RELEASE;
            end
        end else if (start) begin
            // Repeated START beats a coincident STOP
            state_d    = ST_ADDR;
            sda_mode_d = SDA_RELEASE;
        end else if (stop) begin
            state_d    = ST_IDLE;
            sda_mode_d = SDA_RELEASE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (prep_rise_c && byte_received) begin
                        if (rx_data[7:1] == slave_addr) begin
                            sda_mode_d   = SDA_ACK;
                            rw_mode_d    = rx_data[0];
                            addr_match_d = 1'b1;
                            state_d      = ST_ADDR_ACK;
                        end else begin
                            sda_mode_d = SDA_RELEASE;
                            state_d    = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (done_rise_c) begin
                        sda_mode_d = SDA_RELEASE;
                        if (rw_mode_q) begin
                            tx_load_c = 1'b1;
                            state_d   = ST_TX_BYTE;
                        end else begin
                            state_d = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (prep_rise_c && byte_received) begin
                        if (!rx_fifo_full) begin
                            rx_wdata_d = rx_data;
                            rx_push_d  = 1'b1;
                            sda_mode_d = SDA_ACK;
                            state_d    = ST_RX_ACK;
                        end else begin
                            sda_mode_d = SDA_RELEASE;
                            overrun_d  = 1'b1;
                            state_d    = ST_WAIT_STOP;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (done_rise_c) begin
                        sda_mode_d = SDA_RELEASE;
                        state_d    = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    if (prep_rise_c) begin
                        // Release for the master's ACK bit; assume NACK until sampled
                        sda_mode_d = SDA_RELEASE;
                        nack_d     = 1'b1;
                        state_d    = ST_TX_ACK;
                    end
                end
                ST_TX_ACK: begin
                    if (check_rise_c) begin
                        nack_d = sda_in;
                    end
                    if (done_rise_c) begin
                        if (!nack_q) begin
                            tx_load_c = 1'b1;
                            state_d   = ST_TX_BYTE;
                        end else begin
                            master_nack_d = 1'b1;
                            state_d       = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    sda_mode_d = SDA_RELEASE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Load the next TX byte, filling with IDLE_FILL when the FIFO is dry
        if (tx_load_c) begin
            load_tx_d  = 1'b1;
            sda_mode_d = SDA_TX;
            if (tx_fifo_empty) begin
                tx_byte_d  = IDLE_FILL;
                underrun_d = 1'b1;
            end else begin
                tx_byte_d = tx_fifo_rdata;
                tx_pop_d  = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset releases SDA without waiting for a clock
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            sda_mode_q    <= SDA_RELEASE;
            rw_mode_q     <= 1'b0;
            tx_byte_q     <= 8'h00;
            rx_wdata_q    <= 8'h00;
            nack_q        <= 1'b1;
            busy_q        <= 1'b0;
            load_tx_q     <= 1'b0;
            tx_pop_q      <= 1'b0;
            rx_push_q     <= 1'b0;
            addr_match_q  <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
            master_nack_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sda_mode_q    <= sda_mode_d;
            rw_mode_q     <= rw_mode_d;
            tx_byte_q     <= tx_byte_d;
            rx_wdata_q    <= rx_wdata_d;
            nack_q        <= nack_d;
            busy_q        <= busy_d;
            load_tx_q     <= load_tx_d;
            tx_pop_q      <= tx_pop_d;
            rx_push_q     <= rx_push_d;
            addr_match_q  <= addr_match_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
            master_nack_q <= master_nack_d;
        end
    end

    assign sda_mode    = sda_mode_q;
    assign load_tx     = load_tx_q;
    assign tx_byte     = tx_byte_q;
    assign tx_pop      = tx_pop_q;
    assign rx_push     = rx_push_q;
    assign rx_wdata    = rx_wdata_q;
    assign rw_mode     = rw_mode_q;
    assign busy        = busy_q;
    assign addr_match  = addr_match_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;
    assign master_nack = master_nack_q;

endmodule
